// File: rtl/tug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tug_pkg
//  Description : Shared types and constants for the Tug of War match
//                controller: match states, side encoding, score width and
//                a small score helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tug_pkg;

    localparam int SCORE_W = 3;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        PLAY  = 2'd1,
        DONE  = 2'd2
    } match_state_t;

    typedef enum logic {
        SIDE_L = 1'b0,
        SIDE_R = 1'b1
    } side_t;

    // Score increment that holds at the ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        score_inc = (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tug_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : tug_edge_det
//  Description : Rising-edge detector. The history register resets to 1 so
//                a level already high when reset releases is not reported
//                as an edge.
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                sig_i   - level input
//                rise_o  - one-cycle pulse: sig_i high now, low last sample
//  Revision    : 1.0 - initial release
// ============================================================================
module tug_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/tug_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tug_match_ctrl
//  Description : Best-of match controller for Tug of War. Edge-detects the
//                playfield's round-win levels, keeps per-side scores, holds
//                the playfield in round reset between rounds, declares the
//                match winner and starts a new match on a restart edge.
//  Ports       : clk        - clock, all state on rising edge
//                reset      - asynchronous active-low reset
//                win_l      - left (computer) won the round, level
//                win_r      - right (player) won the round, level
//                restart    - rising edge starts a new match
//                round_rst  - registered, high holds playfield in reset
//                score_l    - left round-win count
//                score_r    - right round-win count
//                match_over - registered, high once a side has won
//                winner     - 0 = left, 1 = right; valid with match_over
//  Revision    : 1.0 - initial release
// ============================================================================
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int WINS_TO_MATCH = 7,
    parameter int PAUSE_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               win_l,
    input  logic               win_r,
    input  logic               restart,
    output logic               round_rst,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               match_over,
    output logic               winner
);

    localparam int CNT_W = $clog2(PAUSE_CYCLES + 1);

    localparam logic [CNT_W-1:0]   c_PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_WIN_SCORE  = SCORE_W'(WINS_TO_MATCH);

    // ------------------------------------------------------------------
    // Input edge detection
    // ------------------------------------------------------------------
    logic w_ev_l;
    logic w_ev_r;
    logic w_ev_restart;

    tug_edge_det u_edge_l (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (win_l),
        .rise_o (w_ev_l)
    );

    tug_edge_det u_edge_r (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (win_r),
        .rise_o (w_ev_r)
    );

    tug_edge_det u_edge_restart (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (restart),
        .rise_o (w_ev_restart)
    );

    // ------------------------------------------------------------------
    // Match state
    // ------------------------------------------------------------------
    match_state_t       state_q,      state_d;
    logic [CNT_W-1:0]   pause_cnt_q,  pause_cnt_d;
    logic [SCORE_W-1:0] score_l_q,    score_l_d;
    logic [SCORE_W-1:0] score_r_q,    score_r_d;
    logic               match_over_q, match_over_d;
    side_t              winner_q,     winner_d;
    logic               round_rst_q,  round_rst_d;

    logic [SCORE_W-1:0] w_score_l_inc;
    logic [SCORE_W-1:0] w_score_r_inc;

    assign w_score_l_inc = score_inc(score_l_q);
    assign w_score_r_inc = score_inc(score_r_q);

    always_comb begin
        state_d      = state_q;
        pause_cnt_d  = pause_cnt_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        match_over_d = match_over_q;
        winner_d     = winner_q;

        if (w_ev_restart) begin
            // Restart wins over any same-cycle round result.
            state_d      = PAUSE;
            pause_cnt_d  = '0;
            score_l_d    = '0;
            score_r_d    = '0;
            match_over_d = 1'b0;
            winner_d     = SIDE_L;
        end else begin
            case (state_q)
                PAUSE: begin
                    if (pause_cnt_q == c_PAUSE_LAST) begin
                        state_d     = PLAY;
                        pause_cnt_d = '0;
                    end else begin
                        pause_cnt_d = pause_cnt_q + 1'b1;
                    end
                end

                PLAY: begin
                    if (w_ev_l && w_ev_r) begin
                        // Tie: nobody scores, replay the round.
                        state_d = PAUSE;
                    end else if (w_ev_l) begin
                        score_l_d = w_score_l_inc;
                        if (w_score_l_inc == c_WIN_SCORE) begin
                            state_d      = DONE;
                            match_over_d = 1'b1;
                            winner_d     = SIDE_L;
                        end else begin
                            state_d = PAUSE;
                        end
                    end else if (w_ev_r) begin
                        score_r_d = w_score_r_inc;
                        if (w_score_r_inc == c_WIN_SCORE) begin
                            state_d      = DONE;
                            match_over_d = 1'b1;
                            winner_d     = SIDE_R;
                        end else begin
                            state_d = PAUSE;
                        end
                    end
                end

                DONE: begin
                    // Frozen until a restart edge.
                end

                default: begin
                    state_d     = PAUSE;
                    pause_cnt_d = '0;
                end
            endcase
        end

        // Registered so round_rst tracks the state being entered.
        round_rst_d = (state_d != PLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PAUSE;
            pause_cnt_q  <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            match_over_q <= 1'b0;
            winner_q     <= SIDE_L;
            round_rst_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            pause_cnt_q  <= pause_cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            match_over_q <= match_over_d;
            winner_q     <= winner_d;
            round_rst_q  <= round_rst_d;
        end
    end

    assign round_rst  = round_rst_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign match_over = match_over_q;
    assign winner     = winner_q;

endmodule
`default_nettype wire
